// File: rtl/inst_rom_resp_2023211063_pkg.sv
// Shared types and constants for the instruction-fetch ROM responder.
package inst_rom_resp_2023211063_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;
  localparam int MEM_ADDR_W  = 32;

  localparam logic [INST_W-1:0] INST_NOP  = 32'h0000_0013;
  localparam logic [INST_W-1:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic {
    IROM_IDLE = 1'b0,
    IROM_BUSY = 1'b1
  } irom_state_e;

  typedef struct packed {
    logic [INST_ADDR_W-1:0] raddr;
    logic [INST_W-1:0]      rdata;
    logic                   rerr;
  } irom_resp_t;

  // Word-aligned and inside [base, base + 4*depth); addresses below base wrap high.
  function automatic logic addr_ok(input logic [31:0] addr,
                                   input logic [31:0] base,
                                   input logic [31:0] depth);
    logic [31:0] off;
    off = addr - base;
    return (addr[1:0] == 2'b00) && ((off >> 2) < depth);
  endfunction

endpackage

// File: rtl/inst_rom_resp_2023211063_fifo.sv
// Two-entry response FIFO; flush and reset drop every buffered response.
module resp_fifo_2023211063
  import inst_rom_resp_2023211063_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [INST_ADDR_W-1:0] push_raddr,
  input  logic [INST_W-1:0]      push_rdata,
  input  logic                   push_rerr,
  output logic [INST_ADDR_W-1:0] head_raddr,
  output logic [INST_W-1:0]      head_rdata,
  output logic                   head_rerr,
  output logic [1:0]             count
);

  irom_resp_t entries [2];
  logic       wr_ptr, rd_ptr;
  logic [1:0] count_q;
  logic       do_pop;

  assign do_pop = pop && (count_q != 2'd0);
  assign count  = count_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push)   wr_ptr <= ~wr_ptr;
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the head is only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) begin
      entries[wr_ptr].raddr <= push_raddr;
      entries[wr_ptr].rdata <= push_rdata;
      entries[wr_ptr].rerr  <= push_rerr;
    end
  end

  assign head_raddr = entries[rd_ptr].raddr;
  assign head_rdata = entries[rd_ptr].rdata;
  assign head_rerr  = entries[rd_ptr].rerr;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst || flush)
    !(push && !do_pop && count_q == 2'd2));
  a_count_range: assert property (@(posedge clk) disable iff (rst)
    count_q != 2'd3);

endmodule

// File: rtl/inst_rom_resp_2023211063.sv
// Instruction-fetch bus slave: word array, wait-state FSM and a 2-deep response buffer.
module inst_rom_resp_2023211063
  import inst_rom_resp_2023211063_pkg::*;
#(
  parameter int          DEPTH       = 4096,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter              INIT_FILE   = ""
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_i,
  input  logic [INST_ADDR_W-1:0] addr_i,
  output logic                   gnt_o,
  input  logic                   flush_i,
  output logic                   rvalid_o,
  input  logic                   rready_i,
  output logic [INST_W-1:0]      rdata_o,
  output logic [INST_ADDR_W-1:0] raddr_o,
  output logic                   rerr_o,
  input  logic                   we_i,
  input  logic [MEM_ADDR_W-1:0]  waddr_i,
  input  logic [INST_W-1:0]      wdata_i
);

  localparam int         IDX_W   = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  logic [INST_W-1:0] mem [DEPTH];

  irom_state_e            state_q, state_d;
  logic [3:0]             cnt_q;
  logic [INST_ADDR_W-1:0] addr_q;
  logic                   cnt_zero, accept, push, pop;
  logic [1:0]             count;

  logic [31:0]            rd_off, wr_off;
  logic [IDX_W-1:0]       rd_idx, wr_idx;
  logic                   rd_ok, wr_ok;
  irom_resp_t             push_resp;

  logic [INST_ADDR_W-1:0] head_raddr;
  logic [INST_W-1:0]      head_rdata;
  logic                   head_rerr;

  // Array: asynchronous read of the latched address, write port gated by the range check.
  assign rd_off = addr_q - ADDR_BASE;
  assign rd_idx = rd_off[IDX_W+1:2];
  assign rd_ok  = addr_ok(addr_q, ADDR_BASE, 32'(DEPTH));

  assign wr_off = waddr_i - ADDR_BASE;
  assign wr_idx = wr_off[IDX_W+1:2];
  assign wr_ok  = addr_ok(waddr_i, ADDR_BASE, 32'(DEPTH));

  always_ff @(posedge clk) begin
    if (!rst && we_i && wr_ok) mem[wr_idx] <= wdata_i;
  end

  always_comb begin
    push_resp.raddr = addr_q;
    push_resp.rerr  = !rd_ok;
    push_resp.rdata = rd_ok ? mem[rd_idx] : INST_NOP;
  end

  // FSM: state register / next state / outputs.
  assign cnt_zero = (cnt_q == 4'd0);
  assign accept   = req_i && gnt_o;

  always_ff @(posedge clk) begin
    if (rst || flush_i) state_q <= IROM_IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IROM_IDLE: if (accept) state_d = IROM_BUSY;
      IROM_BUSY: if (cnt_zero && !accept) state_d = IROM_IDLE;
      default:   state_d = IROM_IDLE;
    endcase
  end

  // A back-to-back grant in BUSY is safe when the head leaves at the same edge,
  // which is what keeps a single-cycle stream flowing with rready held high.
  always_comb begin
    gnt_o = 1'b0;
    push  = 1'b0;
    if (!rst && !flush_i) begin
      case (state_q)
        IROM_IDLE: gnt_o = (count < 2'd2);
        IROM_BUSY: begin
          push  = cnt_zero;
          gnt_o = cnt_zero && ((count == 2'd0) || (count == 2'd1 && rready_i));
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      cnt_q  <= 4'd0;
      addr_q <= '0;
    end else if (accept) begin
      cnt_q  <= WAIT_LD;
      addr_q <= addr_i;
    end else if (state_q == IROM_BUSY && !cnt_zero) begin
      cnt_q  <= cnt_q - 4'd1;
    end
  end

  assign pop = rvalid_o && rready_i;

  resp_fifo_2023211063 u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush_i),
    .push       (push),
    .pop        (pop),
    .push_raddr (push_resp.raddr),
    .push_rdata (push_resp.rdata),
    .push_rerr  (push_resp.rerr),
    .head_raddr (head_raddr),
    .head_rdata (head_rdata),
    .head_rerr  (head_rerr),
    .count      (count)
  );

  assign rvalid_o = (count != 2'd0);
  assign rdata_o  = rvalid_o ? head_rdata : ZERO_WORD;
  assign raddr_o  = rvalid_o ? head_raddr : '0;
  assign rerr_o   = rvalid_o && head_rerr;

  a_wait_range: assert property (@(posedge clk) WAIT_CYCLES >= 0 && WAIT_CYCLES <= 15);

endmodule
